// File: rtl/ex_stage_pkg.sv
// Shared core encodings for the execute stage: ALU op codes and memory op codes.
// Load/store codes are also consumed by the MEM stage.
package ex_stage_pkg;

    localparam int CORE_ALU_OP_W = 4;
    localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_ADD  = 4'd0;
    localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_SUB  = 4'd1;
    localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_SLL  = 4'd2;
    localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_SLT  = 4'd3;
    localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_SLTU = 4'd4;
    localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_XOR  = 4'd5;
    localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_SRL  = 4'd6;
    localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_SRA  = 4'd7;
    localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_OR   = 4'd8;
    localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_AND  = 4'd9;
    localparam logic [CORE_ALU_OP_W-1:0] CORE_ALU_OP_PASS = 4'd10;

    localparam int CORE_MEM_RD_OP_W = 3;
    localparam logic [CORE_MEM_RD_OP_W-1:0] CORE_MEM_NO_RD = 3'd0;
    localparam logic [CORE_MEM_RD_OP_W-1:0] CORE_MEM_LB    = 3'd1;
    localparam logic [CORE_MEM_RD_OP_W-1:0] CORE_MEM_LH    = 3'd2;
    localparam logic [CORE_MEM_RD_OP_W-1:0] CORE_MEM_LW    = 3'd3;
    localparam logic [CORE_MEM_RD_OP_W-1:0] CORE_MEM_LBU   = 3'd4;
    localparam logic [CORE_MEM_RD_OP_W-1:0] CORE_MEM_LHU   = 3'd5;

    localparam int CORE_MEM_WR_OP_W = 2;
    localparam logic [CORE_MEM_WR_OP_W-1:0] CORE_MEM_NO_WR = 2'd0;
    localparam logic [CORE_MEM_WR_OP_W-1:0] CORE_MEM_SB    = 2'd1;
    localparam logic [CORE_MEM_WR_OP_W-1:0] CORE_MEM_SH    = 2'd2;
    localparam logic [CORE_MEM_WR_OP_W-1:0] CORE_MEM_SW    = 2'd3;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; results wrap, undefined op codes produce zero.
module alu
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]        op1,
    input  logic [DATA_W-1:0]        op2,
    input  logic [CORE_ALU_OP_W-1:0] alu_op,
    output logic [DATA_W-1:0]        result
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] w_shamt;
    logic            w_lt_signed;
    logic            w_lt_unsigned;

    assign w_shamt       = op2[SH_W-1:0];
    assign w_lt_signed   = $signed(op1) < $signed(op2);
    assign w_lt_unsigned = op1 < op2;

    always_comb begin
        result = '0;
        case (alu_op)
            CORE_ALU_OP_ADD:  result = op1 + op2;
            CORE_ALU_OP_SUB:  result = op1 - op2;
            CORE_ALU_OP_SLL:  result = op1 << w_shamt;
            CORE_ALU_OP_SLT:  result = {{(DATA_W-1){1'b0}}, w_lt_signed};
            CORE_ALU_OP_SLTU: result = {{(DATA_W-1){1'b0}}, w_lt_unsigned};
            CORE_ALU_OP_XOR:  result = op1 ^ op2;
            CORE_ALU_OP_SRL:  result = op1 >> w_shamt;
            CORE_ALU_OP_SRA:  result = $unsigned($signed(op1) >>> w_shamt);
            CORE_ALU_OP_OR:   result = op1 | op2;
            CORE_ALU_OP_AND:  result = op1 & op2;
            CORE_ALU_OP_PASS: result = op2;
            default:          result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, and the ex2mem pipeline registers.
// Always valid; bubbles arrive as reg_wen=0 with NO_RD/NO_WR.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id2ex_reg_wen,
    input  logic [RF_AW-1:0]            id2ex_reg_waddr,
    input  logic [DATA_W-1:0]           id2ex_reg_rs1_data,
    input  logic [DATA_W-1:0]           id2ex_reg_rs2_data,
    input  logic [DATA_W-1:0]           id2ex_imm_value,
    input  logic [CORE_ALU_OP_W-1:0]    id2ex_alu_op,
    input  logic [CORE_MEM_RD_OP_W-1:0] id2ex_mem_rd_op,
    input  logic [CORE_MEM_WR_OP_W-1:0] id2ex_mem_wr_op,
    input  logic                        id2ex_sel_imm,
    input  logic                        id2ex_rs1_forward_from_mem,
    input  logic                        id2ex_rs1_forward_from_wb,
    input  logic                        id2ex_rs2_forward_from_mem,
    input  logic                        id2ex_rs2_forward_from_wb,
    input  logic                        id2ex_ill_instr,
    input  logic [DATA_W-1:0]           wb_reg_wdata,
    output logic                        ex2mem_reg_wen,
    output logic [RF_AW-1:0]            ex2mem_reg_waddr,
    output logic [DATA_W-1:0]           ex2mem_alu_out,
    output logic [DATA_W-1:0]           ex2mem_store_data,
    output logic [CORE_MEM_RD_OP_W-1:0] ex2mem_mem_rd_op,
    output logic [CORE_MEM_WR_OP_W-1:0] ex2mem_mem_wr_op,
    output logic                        ex2mem_ill_instr,
    output logic                        ex_ill_sticky
);

    logic [DATA_W-1:0]           w_op1;
    logic [DATA_W-1:0]           w_rs2_fwd;
    logic [DATA_W-1:0]           w_op2;
    logic [DATA_W-1:0]           w_alu_result;

    logic                        r_reg_wen;
    logic [RF_AW-1:0]            r_reg_waddr;
    logic [DATA_W-1:0]           r_alu_out;
    logic [DATA_W-1:0]           r_store_data;
    logic [CORE_MEM_RD_OP_W-1:0] r_mem_rd_op;
    logic [CORE_MEM_WR_OP_W-1:0] r_mem_wr_op;
    logic                        r_ill_instr;
    logic                        r_ill_sticky;

    // MEM holds the younger producer, so it wins when both forward flags are set.
    assign w_op1 = id2ex_rs1_forward_from_mem ? r_alu_out :
                   id2ex_rs1_forward_from_wb  ? wb_reg_wdata :
                                                id2ex_reg_rs1_data;

    assign w_rs2_fwd = id2ex_rs2_forward_from_mem ? r_alu_out :
                       id2ex_rs2_forward_from_wb  ? wb_reg_wdata :
                                                    id2ex_reg_rs2_data;

    assign w_op2 = id2ex_sel_imm ? id2ex_imm_value : w_rs2_fwd;

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op1    (w_op1),
        .op2    (w_op2),
        .alu_op (id2ex_alu_op),
        .result (w_alu_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_wen    <= 1'b0;
            r_reg_waddr  <= '0;
            r_alu_out    <= '0;
            r_store_data <= '0;
            r_mem_rd_op  <= CORE_MEM_NO_RD;
            r_mem_wr_op  <= CORE_MEM_NO_WR;
            r_ill_instr  <= 1'b0;
            r_ill_sticky <= 1'b0;
        end else begin
            // An illegal instruction must not touch architectural state downstream.
            r_reg_wen    <= id2ex_reg_wen & ~id2ex_ill_instr;
            r_reg_waddr  <= id2ex_reg_waddr;
            r_alu_out    <= w_alu_result;
            r_store_data <= w_rs2_fwd;
            r_mem_rd_op  <= id2ex_ill_instr ? CORE_MEM_NO_RD : id2ex_mem_rd_op;
            r_mem_wr_op  <= id2ex_ill_instr ? CORE_MEM_NO_WR : id2ex_mem_wr_op;
            r_ill_instr  <= id2ex_ill_instr;
            r_ill_sticky <= r_ill_sticky | id2ex_ill_instr;
        end
    end

    assign ex2mem_reg_wen    = r_reg_wen;
    assign ex2mem_reg_waddr  = r_reg_waddr;
    assign ex2mem_alu_out    = r_alu_out;
    assign ex2mem_store_data = r_store_data;
    assign ex2mem_mem_rd_op  = r_mem_rd_op;
    assign ex2mem_mem_wr_op  = r_mem_wr_op;
    assign ex2mem_ill_instr  = r_ill_instr;
    assign ex_ill_sticky     = r_ill_sticky;

endmodule
